deserializador: RTL

DESERIALIZADOR -- requirements
Module: deserializador

---
 rtl/deserializador_if.sv | 26 ++
 rtl/deserializador.sv | 120 ++++++++++++
 2 files changed

// File: rtl/deserializador_if.sv
// Handshake bundle between a serial bit source and the deserializador word consumer.
// The slave modport is the deserializador side; master is the driving side.
interface deserializador_if #(
    parameter int size = 8
);
    logic            sin;
    logic            sin_valid;
    logic            sof;
    logic            msb_first;
    logic            sin_ready;
    logic [size-1:0] dout;
    logic            dout_valid;
    logic            dout_ready;
    logic            frame_err;
    logic            parity_err;

    modport master (
        output sin, sin_valid, sof, msb_first, dout_ready,
        input  sin_ready, dout, dout_valid, frame_err, parity_err
    );

    modport slave (
        input  sin, sin_valid, sof, msb_first, dout_ready,
        output sin_ready, dout, dout_valid, frame_err, parity_err
    );
endinterface

// File: rtl/deserializador.sv
// Serial-to-parallel converter with per-frame bit order and frame-abort detection.
// Optional even-parity bit after the data bits when DESERIALIZADOR_PARITY_EN is defined.
module deserializador #(
    parameter int size = 8
) (
    input logic            clk,
    input logic            rst_n,
    deserializador_if.slave bus
);
    localparam int CW = $clog2(size + 1);
`ifdef DESERIALIZADOR_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    typedef enum logic [1:0] {IDLE, RECV, PAR, FULL} state_t;
`else
    localparam bit PAR_EN = 1'b0;
    typedef enum logic [1:0] {IDLE, RECV, FULL} state_t;
`endif

    state_t          state_q, state_d;
    logic [size-1:0] word_q, word_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            msb_q, msb_d;
    logic            ferr_q, ferr_d;
    logic            perr_q, perr_d;

    logic            ready;
    logic            accept;
    logic            start;
    logic            in_frame;
    logic            ins_msb;
    logic [size-1:0] ins_word;

    assign ready  = (state_q == FULL) ? bus.dout_ready : 1'b1;
    assign accept = bus.sin_valid & ready;
    assign start  = accept & bus.sof;

`ifdef DESERIALIZADOR_PARITY_EN
    assign in_frame = (state_q == RECV) || (state_q == PAR);
`else
    assign in_frame = (state_q == RECV);
`endif

    // The first bit of a frame must use the order being latched, not the stale one.
    assign ins_msb  = start ? bus.msb_first : msb_q;
    assign ins_word = ins_msb ? {word_q[size-2:0], bus.sin}
                              : {bus.sin, word_q[size-1:1]};

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        msb_d   = msb_q;
        ferr_d  = 1'b0;
        perr_d  = perr_q;

        // Any accepted sof restarts; in FULL an accept already implies the handshake.
        if (start) begin
            state_d = RECV;
            word_d  = ins_word;
            cnt_d   = CW'(1);
            msb_d   = bus.msb_first;
            perr_d  = bus.sin;
            ferr_d  = in_frame;
        end else begin
            case (state_q)
                IDLE: ;
                RECV: begin
                    if (accept) begin
                        word_d = ins_word;
                        cnt_d  = cnt_q + CW'(1);
                        perr_d = perr_q ^ bus.sin;
                        if (cnt_q == CW'(size - 1)) begin
`ifdef DESERIALIZADOR_PARITY_EN
                            state_d = PAR;
`else
                            state_d = FULL;
`endif
                        end
                    end
                end
`ifdef DESERIALIZADOR_PARITY_EN
                PAR: begin
                    if (accept) begin
                        perr_d  = perr_q ^ bus.sin;
                        state_d = FULL;
                    end
                end
`endif
                FULL: begin
                    if (bus.dout_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            msb_q   <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            msb_q   <= msb_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    assign bus.sin_ready  = ready;
    assign bus.dout       = word_q;
    assign bus.dout_valid = (state_q == FULL);
    assign bus.frame_err  = ferr_q;
    assign bus.parity_err = PAR_EN & perr_q;
endmodule
